// File: rtl/mandelbrot_pkg.sv
// Shared widths, state encoding and constants for the Mandelbrot pixel dispatcher.
package mandelbrot_pkg;

    localparam int DEF_INTEGER_BITS    = 8;
    localparam int DEF_FRACTIONAL_BITS = 24;
    localparam int DEF_MAX_ITER_WIDTH  = 16;
    localparam int DEF_PIX_WIDTH       = 12;

    // Extra WAIT cycles granted beyond max_iter before a core is declared hung.
    localparam int WDOG_MARGIN = 16;

    function automatic int data_width(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    localparam int DEF_DATA_WIDTH = data_width(DEF_INTEGER_BITS, DEF_FRACTIONAL_BITS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_EMIT   = 3'd4
    } dispatch_state_e;

endpackage

// File: rtl/mandelbrot_dispatcher_if.sv
// Pixel result stream from the dispatcher to its consumer.
interface mandelbrot_dispatcher_if #(
    parameter int PIX_WIDTH      = 12,
    parameter int MAX_ITER_WIDTH = 16
);

    // A beat transfers on a rising edge where pix_valid and pix_ready are both 1;
    // once pix_valid rises, it and all payload stay stable until that transfer.
    logic                      pix_valid;
    logic                      pix_ready;
    logic [PIX_WIDTH-1:0]      pix_x;
    logic [PIX_WIDTH-1:0]      pix_y;
    logic [MAX_ITER_WIDTH-1:0] pix_iter;
    logic                      pix_last;

    modport master (output pix_valid, pix_x, pix_y, pix_iter, pix_last, input pix_ready);
    modport slave  (input pix_valid, pix_x, pix_y, pix_iter, pix_last, output pix_ready);

endinterface

// File: rtl/mandelbrot_coord_gen.sv
// Raster walker: pixel counters and fixed-point coordinate stepping, top-left to bottom-right.
module mandelbrot_coord_gen
    import mandelbrot_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PIX_WIDTH  = DEF_PIX_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_i,
    input  logic                         advance_i,
    input  logic signed [DATA_WIDTH-1:0] x_min_i,
    input  logic signed [DATA_WIDTH-1:0] y_max_i,
    input  logic signed [DATA_WIDTH-1:0] step_i,
    input  logic        [PIX_WIDTH-1:0]  width_i,
    input  logic        [PIX_WIDTH-1:0]  height_i,
    output logic        [PIX_WIDTH-1:0]  px_o,
    output logic        [PIX_WIDTH-1:0]  py_o,
    output logic signed [DATA_WIDTH-1:0] cur_x_o,
    output logic signed [DATA_WIDTH-1:0] cur_y_o,
    output logic                         last_o
);

    logic signed [DATA_WIDTH-1:0] x_min_q;
    logic signed [DATA_WIDTH-1:0] step_q;
    logic        [PIX_WIDTH-1:0]  width_q;
    logic        [PIX_WIDTH-1:0]  height_q;
    logic                         row_end;

    assign row_end = (px_o == width_q - PIX_WIDTH'(1));
    assign last_o  = row_end && (py_o == height_q - PIX_WIDTH'(1));

    // Coordinates wrap at DATA_WIDTH; y decreases because rows run top-down.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_min_q  <= '0;
            step_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
            px_o     <= '0;
            py_o     <= '0;
            cur_x_o  <= '0;
            cur_y_o  <= '0;
        end else if (load_i) begin
            x_min_q  <= x_min_i;
            step_q   <= step_i;
            width_q  <= width_i;
            height_q <= height_i;
            px_o     <= '0;
            py_o     <= '0;
            cur_x_o  <= x_min_i;
            cur_y_o  <= y_max_i;
        end else if (advance_i) begin
            if (row_end) begin
                px_o    <= '0;
                cur_x_o <= x_min_q;
                py_o    <= py_o + PIX_WIDTH'(1);
                cur_y_o <= cur_y_o - step_q;
            end else begin
                px_o    <= px_o + PIX_WIDTH'(1);
                cur_x_o <= cur_x_o + step_q;
            end
        end
    end

endmodule

// File: rtl/mandelbrot_dispatcher.sv
// Walks a frame pixel by pixel through one Mandelbrot core and streams the results.
// Build option MANDEL_DISPATCH_WDOG_EN adds a hung-core watchdog and the wdog_err_o port.
module mandelbrot_dispatcher
    import mandelbrot_pkg::*;
#(
    parameter int  INTEGER_BITS    = DEF_INTEGER_BITS,
    parameter int  FRACTIONAL_BITS = DEF_FRACTIONAL_BITS,
    parameter int  MAX_ITER_WIDTH  = DEF_MAX_ITER_WIDTH,
    parameter int  PIX_WIDTH       = DEF_PIX_WIDTH,
    localparam int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         frame_start_i,
    input  logic signed [DATA_WIDTH-1:0] x_min_i,
    input  logic signed [DATA_WIDTH-1:0] y_max_i,
    input  logic signed [DATA_WIDTH-1:0] step_i,
    input  logic [PIX_WIDTH-1:0]         width_i,
    input  logic [PIX_WIDTH-1:0]         height_i,
    input  logic [MAX_ITER_WIDTH-1:0]    max_iter_i,
    output logic                         core_start_o,
    output logic signed [DATA_WIDTH-1:0] core_x0_o,
    output logic signed [DATA_WIDTH-1:0] core_y0_o,
    output logic [MAX_ITER_WIDTH-1:0]    core_max_iter_o,
    input  logic [MAX_ITER_WIDTH-1:0]    core_iter_i,
    input  logic                         core_done_i,
    mandelbrot_dispatcher_if.master      pix,
    output logic                         busy_o,
    output logic                         frame_done_o,
`ifdef MANDEL_DISPATCH_WDOG_EN
    output logic                         wdog_err_o,
`endif
    output dispatch_state_e              state_o
);

    dispatch_state_e              state_q, state_d;
    logic [MAX_ITER_WIDTH-1:0]    max_iter_q;
    logic [MAX_ITER_WIDTH-1:0]    pix_iter_q;
    logic signed [DATA_WIDTH-1:0] core_x0_q;
    logic signed [DATA_WIDTH-1:0] core_y0_q;
    logic                         frame_done_q;
    logic [PIX_WIDTH-1:0]         px, py;
    logic signed [DATA_WIDTH-1:0] cur_x, cur_y;
    logic                         last;
    logic                         frame_go;
    logic                         zero_frame;
    logic                         handshake;
    logic                         wdog_fire;

    assign frame_go   = (state_q == ST_IDLE) && frame_start_i;
    assign zero_frame = (width_i == '0) || (height_i == '0);
    assign handshake  = (state_q == ST_EMIT) && pix.pix_ready;

    mandelbrot_coord_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .PIX_WIDTH  (PIX_WIDTH)
    ) u_coord_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (frame_go),
        .advance_i (handshake),
        .x_min_i   (x_min_i),
        .y_max_i   (y_max_i),
        .step_i    (step_i),
        .width_i   (width_i),
        .height_i  (height_i),
        .px_o      (px),
        .py_o      (py),
        .cur_x_o   (cur_x),
        .cur_y_o   (cur_y),
        .last_o    (last)
    );

`ifdef MANDEL_DISPATCH_WDOG_EN
    localparam int WDOG_W = MAX_ITER_WIDTH + 1;
    logic [WDOG_W-1:0] wdog_cnt_q;
    logic [WDOG_W-1:0] wdog_limit;
    logic              wdog_err_q;

    // Counter equals the number of WAIT cycles already spent; fires on the last allowed one.
    assign wdog_limit = {1'b0, max_iter_q} + WDOG_W'(WDOG_MARGIN - 1);
    assign wdog_fire  = (state_q == ST_WAIT) && !core_done_i && (wdog_cnt_q == wdog_limit);
    assign wdog_err_o = wdog_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= (state_q == ST_WAIT) ? wdog_cnt_q + WDOG_W'(1) : '0;
            if (frame_go)
                wdog_err_q <= 1'b0;
            else if (wdog_fire)
                wdog_err_q <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // SETTLE exists because core_done_i is still high from the previous pixel.
    always_comb begin
        state_d       = state_q;
        core_start_o  = 1'b0;
        busy_o        = 1'b1;
        pix.pix_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (frame_start_i && !zero_frame)
                    state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                core_start_o = 1'b1;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_done_i || wdog_fire)
                    state_d = ST_EMIT;
            end
            ST_EMIT: begin
                pix.pix_valid = 1'b1;
                if (pix.pix_ready)
                    state_d = last ? ST_IDLE : ST_ISSUE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            max_iter_q   <= '0;
            pix_iter_q   <= '0;
            core_x0_q    <= '0;
            core_y0_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= (frame_go && zero_frame) || (handshake && last);
            if (frame_go)
                max_iter_q <= max_iter_i;
            if (state_q == ST_ISSUE) begin
                core_x0_q <= cur_x;
                core_y0_q <= cur_y;
            end
            if (state_q == ST_WAIT) begin
                if (core_done_i)
                    pix_iter_q <= core_iter_i;
                else if (wdog_fire)
                    pix_iter_q <= max_iter_q;
            end
        end
    end

    assign core_x0_o       = (state_q == ST_ISSUE) ? cur_x : core_x0_q;
    assign core_y0_o       = (state_q == ST_ISSUE) ? cur_y : core_y0_q;
    assign core_max_iter_o = max_iter_q;
    assign frame_done_o    = frame_done_q;
    assign state_o         = state_q;

    assign pix.pix_x    = px;
    assign pix.pix_y    = py;
    assign pix.pix_iter = pix_iter_q;
    assign pix.pix_last = (state_q == ST_EMIT) && last;

endmodule

// File: tb/tb_mandelbrot_dispatcher.sv
// Scoreboard bench for mandelbrot_dispatcher with a behavioural Mandelbrot core stub.
module tb_mandelbrot_dispatcher;
  import mandelbrot_pkg::*;

  localparam int DW = 32;
  localparam int PW = 12;
  localparam int IW = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 frame_start_i;
  logic signed [DW-1:0] x_min_i, y_max_i, step_i;
  logic [PW-1:0]        width_i, height_i;
  logic [IW-1:0]        max_iter_i;
  logic                 core_start_o;
  logic signed [DW-1:0] core_x0_o, core_y0_o;
  logic [IW-1:0]        core_max_iter_o;
  logic [IW-1:0]        core_iter_i;
  logic                 core_done_i;
  logic                 busy_o;
  logic                 frame_done_o;
  dispatch_state_e      state_o;
`ifdef MANDEL_DISPATCH_WDOG_EN
  logic                 wdog_err_o;
`endif

  mandelbrot_dispatcher_if #(.PIX_WIDTH(PW), .MAX_ITER_WIDTH(IW)) pix_if ();

  mandelbrot_dispatcher dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .frame_start_i   (frame_start_i),
    .x_min_i         (x_min_i),
    .y_max_i         (y_max_i),
    .step_i          (step_i),
    .width_i         (width_i),
    .height_i        (height_i),
    .max_iter_i      (max_iter_i),
    .core_start_o    (core_start_o),
    .core_x0_o       (core_x0_o),
    .core_y0_o       (core_y0_o),
    .core_max_iter_o (core_max_iter_o),
    .core_iter_i     (core_iter_i),
    .core_done_i     (core_done_i),
    .pix             (pix_if),
    .busy_o          (busy_o),
    .frame_done_o    (frame_done_o),
`ifdef MANDEL_DISPATCH_WDOG_EN
    .wdog_err_o      (wdog_err_o),
`endif
    .state_o         (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [79:0] exp_core_q[$];  // {x0, y0, max_iter}
  logic [40:0] exp_pix_q[$];   // {x, y, iter, last}
  int fd_due = -1;
  int starts_seen = 0;
  int wait_cycles = 0;
  int core_lat = 0;
  bit never_done = 0;

  function automatic real q2r(input logic [31:0] v);
    return $itor($signed(v)) / 16777216.0;
  endfunction

  function automatic int mandel(input real cx, input real cy, input int max_it);
    real zx, zy, t;
    int n;
    zx = 0.0; zy = 0.0; n = 0;
    while (n < max_it) begin
      t  = zx * zx - zy * zy + cx;
      zy = 2.0 * zx * zy + cy;
      zx = t;
      n++;
      if (zx * zx + zy * zy > 4.0) break;
    end
    return n;
  endfunction

  // ---------------- core stub: done level held until a new start is seen ----------------
  initial begin
    int phase, cnt, res;
    phase = 0; cnt = 0; res = 0;
    core_done_i = 1'b0;
    core_iter_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        core_done_i = 1'b0;
        core_iter_i = '0;
        phase = 0;
      end else if (core_start_o) begin
        res = mandel(q2r(core_x0_o), q2r(core_y0_o), int'(core_max_iter_o));
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;  // stale done still visible while the dispatcher settles
      end else if (phase == 2) begin
        core_done_i = 1'b0;
        cnt = core_lat;
        phase = 3;
      end else if (phase == 3 && !never_done) begin
        if (cnt == 0) begin
          core_done_i = 1'b1;
          core_iter_i = IW'(res);
          phase = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    logic [79:0] ec;
    logic [40:0] ep, gp;
    if (!rst_i) begin
      if (state_o == ST_WAIT) wait_cycles++;
      if (core_start_o) begin
        starts_seen++;
        checks++;
        if (exp_core_q.size() == 0) begin
          errors++;
          $display("FAIL core_start: unexpected start x0=%h y0=%h, required none", core_x0_o, core_y0_o);
        end else begin
          ec = exp_core_q.pop_front();
          if ({core_x0_o, core_y0_o, core_max_iter_o} !== ec) begin
            errors++;
            $display("FAIL core_start: got x0=%h y0=%h mi=%0d, required x0=%h y0=%h mi=%0d",
                     core_x0_o, core_y0_o, core_max_iter_o, ec[79:48], ec[47:16], ec[15:0]);
          end
        end
      end
      if (pix_if.pix_valid) begin
        gp = {pix_if.pix_x, pix_if.pix_y, pix_if.pix_iter, pix_if.pix_last};
        checks++;
        if (exp_pix_q.size() == 0) begin
          errors++;
          $display("FAIL pixel: unexpected pixel %h, required none", gp);
        end else begin
          ep = exp_pix_q[0];
          if (gp !== ep) begin
            errors++;
            $display("FAIL pixel: got x=%0d y=%0d iter=%0d last=%0d, required x=%0d y=%0d iter=%0d last=%0d",
                     gp[40:29], gp[28:17], gp[16:1], gp[0], ep[40:29], ep[28:17], ep[16:1], ep[0]);
          end
          if (pix_if.pix_ready) begin
            void'(exp_pix_q.pop_front());
            if (ep[0]) fd_due = cyc + 1;
          end
        end
      end
      if (frame_done_o || cyc == fd_due) begin
        checks++;
        if (frame_done_o !== (cyc == fd_due)) begin
          errors++;
          $display("FAIL frame_done: got %0b at cycle %0d, required %0b", frame_done_o, cyc, cyc == fd_due);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push_core(input logic [31:0] x, input logic [31:0] y, input logic [15:0] mi);
    exp_core_q.push_back({x, y, mi});
  endtask

  task automatic push_pix(input int x, input int y, input int it, input bit last);
    exp_pix_q.push_back({PW'(x), PW'(y), IW'(it), last});
  endtask

  task automatic start_frame(input logic [31:0] xm, input logic [31:0] ym, input logic [31:0] st,
                             input int w, input int h, input int mi);
    x_min_i = xm; y_max_i = ym; step_i = st;
    width_i = PW'(w); height_i = PW'(h); max_iter_i = IW'(mi);
    frame_start_i = 1'b1;
    if (w == 0 || h == 0) fd_due = cyc + 1;
    tick(1);
    frame_start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy_o || exp_pix_q.size() != 0 || exp_core_q.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles, pixels left=%0d starts left=%0d, required 0",
               name, n, exp_pix_q.size(), exp_core_q.size());
    end
    tick(2);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({core_start_o, core_x0_o, core_y0_o, core_max_iter_o, pix_if.pix_valid, pix_if.pix_x,
         pix_if.pix_y, pix_if.pix_iter, pix_if.pix_last, busy_o, frame_done_o, state_o} !== '0) begin
      errors++;
      $display("FAIL %s: outputs not zero: start=%0b x0=%h y0=%h mi=%0d valid=%0b px=%0d py=%0d it=%0d last=%0b busy=%0b fd=%0b st=%0d, required all 0",
               name, core_start_o, core_x0_o, core_y0_o, core_max_iter_o, pix_if.pix_valid, pix_if.pix_x,
               pix_if.pix_y, pix_if.pix_iter, pix_if.pix_last, busy_o, frame_done_o, state_o);
    end
  endtask

  task automatic push_frame_2x2;
    push_core(32'hFE000000, 32'h01000000, 16'd16);
    push_core(32'hFE800000, 32'h01000000, 16'd16);
    push_core(32'hFE000000, 32'h00800000, 16'd16);
    push_core(32'hFE800000, 32'h00800000, 16'd16);
    push_pix(0, 0, 1, 0);
    push_pix(1, 0, 2, 0);
    push_pix(0, 1, 1, 0);
    push_pix(1, 1, 3, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_i = 1'b1;
    frame_start_i = 1'b0;
    x_min_i = '0; y_max_i = '0; step_i = '0;
    width_i = '0; height_i = '0; max_iter_i = '0;
    pix_if.pix_ready = 1'b1;

    tick(3);
    check_zero("reset_held");
    rst_i = 1'b0;
    tick(1);
    check_zero("after_reset");

    // 2x2 raster from (-2,1) with 0.5 pitch; inputs scrambled and a stray start mid-frame
    push_frame_2x2();
    start_frame(32'hFE000000, 32'h01000000, 32'h00800000, 2, 2, 16);
    x_min_i = 32'h11111111; y_max_i = 32'h22222222; step_i = 32'h33333333;
    width_i = 12'd7; height_i = 12'd7; max_iter_i = 16'd99;
    tick(3);
    frame_start_i = 1'b1;
    tick(1);
    frame_start_i = 1'b0;
    wait_idle("frame_2x2", 500);

    // single pixels: interior point hits the limit, far point escapes at once
    core_lat = 5;
    push_core(32'h00000000, 32'h00000000, 16'd16);
    push_pix(0, 0, 16, 1);
    start_frame(32'h00000000, 32'h00000000, 32'h00800000, 1, 1, 16);
    wait_idle("pixel_origin", 500);
    push_core(32'h02000000, 32'h02000000, 16'd16);
    push_pix(0, 0, 1, 1);
    start_frame(32'h02000000, 32'h02000000, 32'h00800000, 1, 1, 16);
    wait_idle("pixel_far", 500);

    // backpressure: first pixel held for five cycles
    core_lat = 1;
    pix_if.pix_ready = 1'b0;
    push_core(32'h00000000, 32'h00000000, 16'd4);
    push_core(32'h03000000, 32'h00000000, 16'd4);
    push_pix(0, 0, 4, 0);
    push_pix(1, 0, 1, 1);
    start_frame(32'h00000000, 32'h00000000, 32'h03000000, 2, 1, 4);
    n = 0;
    while (!pix_if.pix_valid && n < 100) begin tick(1); n++; end
    repeat (5) begin
      @(negedge clk_i);
      checks++;
      if ({pix_if.pix_valid, core_start_o} !== 2'b10) begin
        errors++;
        $display("FAIL stall_hold: got valid=%0b start=%0b, required valid=1 start=0",
                 pix_if.pix_valid, core_start_o);
      end
    end
    tick(1);
    pix_if.pix_ready = 1'b1;
    wait_idle("stall", 500);

    // empty frame: immediate done, no core activity
    start_frame(32'hFE000000, 32'h01000000, 32'h00800000, 0, 3, 16);
    tick(1);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_frame_busy: got %0b, required 0", busy_o);
    end
    tick(4);

    // x coordinate wraps from +127.5 to -128.0
    push_core(32'h7F800000, 32'h00000000, 16'd16);
    push_core(32'h80000000, 32'h00000000, 16'd16);
    push_pix(0, 0, 1, 0);
    push_pix(1, 0, 1, 1);
    start_frame(32'h7F800000, 32'h00000000, 32'h00800000, 2, 1, 16);
    wait_idle("wrap", 500);

    // reset while waiting on the second pixel, then restart the same frame
    core_lat = 3;
    starts_seen = 0;
    push_frame_2x2();
    start_frame(32'hFE000000, 32'h01000000, 32'h00800000, 2, 2, 16);
    n = 0;
    while (!(starts_seen >= 2 && state_o == ST_WAIT) && n < 200) begin tick(1); n++; end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL reset_setup: never reached WAIT of pixel 2, required reach within 200 cycles");
    end
    rst_i = 1'b1;
    #1;
    check_zero("reset_mid_frame");
    exp_core_q.delete();
    exp_pix_q.delete();
    fd_due = -1;
    tick(2);
    rst_i = 1'b0;
    tick(1);
    check_zero("after_mid_reset");
    push_frame_2x2();
    start_frame(32'hFE000000, 32'h01000000, 32'h00800000, 2, 2, 16);
    wait_idle("restart_2x2", 500);

`ifdef MANDEL_DISPATCH_WDOG_EN
    never_done = 1;
    push_core(32'h00000000, 32'h00000000, 16'd8);
    push_pix(0, 0, 8, 1);
    start_frame(32'h00000000, 32'h00000000, 32'h00800000, 1, 1, 8);
    wait_cycles = 0;
    wait_idle("wdog_frame", 500);
    checks++;
    if (wait_cycles != 24 || wdog_err_o !== 1'b1) begin
      errors++;
      $display("FAIL wdog: got wait_cycles=%0d err=%0b, required 24 and 1", wait_cycles, wdog_err_o);
    end
    never_done = 0;
    start_frame(32'h00000000, 32'h00000000, 32'h00800000, 0, 1, 8);
    tick(2);
    checks++;
    if (wdog_err_o !== 1'b0) begin
      errors++;
      $display("FAIL wdog_clear: got %0b, required 0", wdog_err_o);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
